sound_player: RTL

- Audio back-end for the chess game. Consumes the 1-cycle `play_sound` pulse and 3-bit `sound_code` issued by the game controller.
- Plays the corresponding fixed note sequence as a square wave on a single buzzer pin (board PWM/buzzer output).
- Sits between the game logic and the top-level audio pin, in the same clock domain as the game logic.

---
 rtl/sound_player.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sound_player.sv
// Buzzer back-end: plays a fixed note sequence per sound_code as a square wave,
// with 1-cycle request/preemption, stop, mute and a completion pulse.
module sound_player #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int GAP_MS   = 20
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] sound_code,
  input  logic       play_sound,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic       done,
  output logic [1:0] note_idx
);

  localparam int TICK  = CLK_FREQ / 1000;
  localparam int H_880 = CLK_FREQ / (2 * 880);
  localparam int H_660 = CLK_FREQ / (2 * 660);
  localparam int H_990 = CLK_FREQ / (2 * 990);
  localparam int H_523 = CLK_FREQ / (2 * 523);
  localparam int H_659 = CLK_FREQ / (2 * 659);
  localparam int H_784 = CLK_FREQ / (2 * 784);
  localparam int H_330 = CLK_FREQ / (2 * 330);
  localparam int H_MAX = H_330;
  localparam int PW    = (H_MAX > 1) ? $clog2(H_MAX) : 1;
  localparam int TW    = (TICK > 1) ? $clog2(TICK) : 1;

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  state_t        state;
  logic [2:0]    seq;
  logic [PW-1:0] phase;
  logic [TW-1:0] tick;
  logic [7:0]    ms;
  logic          wave;

  logic [PW-1:0] half;
  logic [7:0]    dur;
  logic [1:0]    last_idx;
  logic          wave_nxt;
  logic          phase_end;
  logic          tick_end;
  logic          tone_end;
  logic          gap_end;
  logic          start;
  logic          stop;

  // Per-note half period, note length in ms and index of the final note.
  always_comb begin
    half     = PW'(H_MAX);
    dur      = 8'd1;
    last_idx = 2'd0;
    case (seq)
      3'd1: begin
        half = PW'(H_880);
        dur  = 8'd80;
      end
      3'd2: begin
        half     = (note_idx == 2'd0) ? PW'(H_660) : PW'(H_990);
        dur      = 8'd60;
        last_idx = 2'd1;
      end
      3'd3: begin
        case (note_idx)
          2'd0:    half = PW'(H_523);
          2'd1:    half = PW'(H_659);
          default: half = PW'(H_784);
        endcase
        dur      = 8'd120;
        last_idx = 2'd2;
      end
      3'd4: begin
        half = PW'(H_330);
        dur  = 8'd200;
      end
      default: ;
    endcase
  end

  always_comb begin
    phase_end = (phase == half - PW'(1));
    wave_nxt  = phase_end ? ~wave : wave;
    tick_end  = (tick == TW'(TICK - 1));
    tone_end  = tick_end && (ms == dur - 8'd1);
    gap_end   = tick_end && (ms == 8'(GAP_MS - 1));
    start     = play_sound && (sound_code != 3'd0) && (sound_code <= 3'd4);
    stop      = play_sound && (sound_code == 3'd0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      seq      <= '0;
      note_idx <= '0;
      phase    <= '0;
      tick     <= '0;
      ms       <= '0;
      wave     <= 1'b0;
      buzzer   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      // A request outranks both stop-less sequencing and a same-cycle completion.
      if (start) begin
        state    <= TONE;
        seq      <= sound_code;
        note_idx <= '0;
        phase    <= '0;
        tick     <= '0;
        ms       <= '0;
        wave     <= 1'b0;
        buzzer   <= 1'b0;
        busy     <= 1'b1;
      end else if (stop) begin
        state    <= IDLE;
        note_idx <= '0;
        phase    <= '0;
        tick     <= '0;
        ms       <= '0;
        wave     <= 1'b0;
        buzzer   <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          TONE: begin
            if (tone_end) begin
              phase  <= '0;
              tick   <= '0;
              ms     <= '0;
              wave   <= 1'b0;
              buzzer <= 1'b0;
              if (note_idx == last_idx) begin
                state    <= IDLE;
                note_idx <= '0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end else begin
                state <= GAP;
              end
            end else begin
              phase  <= phase_end ? '0 : phase + PW'(1);
              wave   <= wave_nxt;
              buzzer <= wave_nxt & ~mute;
              if (tick_end) begin
                tick <= '0;
                ms   <= ms + 8'd1;
              end else begin
                tick <= tick + TW'(1);
              end
            end
          end
          GAP: begin
            if (gap_end) begin
              state    <= TONE;
              note_idx <= note_idx + 2'd1;
              phase    <= '0;
              tick     <= '0;
              ms       <= '0;
            end else if (tick_end) begin
              tick <= '0;
              ms   <= ms + 8'd1;
            end else begin
              tick <= tick + TW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
